regfile_wb_queue: RTL and testbench

REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

---
 rtl/regfile_wb_queue.sv | 137 +++++++++++++
 tb/tb_regfile_wb_queue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - in-order register writeback queue with read bypass
module regfile_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [4:0]                 wr_sel,
  input  logic [31:0]                wr_data,
  input  logic                       wr_hold,
  input  logic [4:0]                 rd_sel1,
  input  logic [4:0]                 rd_sel2,
  output logic [31:0]                rd_dat1,
  output logic [31:0]                rd_dat2,
  output logic                       rf_WEN,
  output logic [4:0]                 rf_wsel,
  output logic [31:0]                rf_wdat,
  output logic [4:0]                 rf_rsel1,
  output logic [4:0]                 rf_rsel2,
  input  logic [31:0]                rf_rdat1,
  input  logic [31:0]                rf_rdat2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry storage; validity is defined solely by head/count, so no reset.
  logic [4:0]    sel_mem  [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  logic          accept;
  logic          push;
  logic          pop;

  logic          hit1;
  logic          hit2;
  logic [31:0]   byp1;
  logic [31:0]   byp2;
  logic [PW-1:0] idx;

  // Status decodes; wr_ready ignores a same-cycle drain so it never depends on wr_hold.
  always_comb begin
    empty    = (count == '0);
    full     = (count == CW'(DEPTH));
    wr_ready = (count < CW'(DEPTH));
  end

  // Handshake: register-zero writes are consumed but never occupy an entry.
  always_comb begin
    accept = wr_valid && wr_ready;
    push   = accept && (wr_sel != 5'd0);
    pop    = !empty && !wr_hold;
  end

  // Register-file write port driven straight from the head entry.
  always_comb begin
    rf_WEN  = 1'b0;
    rf_wsel = 5'd0;
    rf_wdat = 32'd0;
    if (pop) begin
      rf_WEN  = 1'b1;
      rf_wsel = sel_mem[head];
      rf_wdat = data_mem[head];
    end
  end

  // Read ports pass through to the register file.
  always_comb begin
    rf_rsel1 = rd_sel1;
    rf_rsel2 = rd_sel2;
  end

  // Bypass search oldest-to-youngest so the youngest matching entry overrides.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    byp1 = 32'd0;
    byp2 = 32'd0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count) begin
        if (sel_mem[idx] == rd_sel1) begin
          hit1 = 1'b1;
          byp1 = data_mem[idx];
        end
        if (sel_mem[idx] == rd_sel2) begin
          hit2 = 1'b1;
          byp2 = data_mem[idx];
        end
      end
    end
  end

  // Final read mux: register zero reads as zero, then queue hit, then register file.
  always_comb begin
    if (rd_sel1 == 5'd0)  rd_dat1 = 32'd0;
    else if (hit1)        rd_dat1 = byp1;
    else                  rd_dat1 = rf_rdat1;
    if (rd_sel2 == 5'd0)  rd_dat2 = 32'd0;
    else if (hit2)        rd_dat2 = byp2;
    else                  rd_dat2 = rf_rdat2;
  end

  // Write the tail entry on push.
  always_ff @(posedge CLK) begin
    if (push) begin
      sel_mem[tail]  <= wr_sel;
      data_mem[tail] <= wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb/tb_regfile_wb_queue.sv - self-checking bench for regfile_wb_queue
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          wr_valid;
  logic          wr_ready;
  logic [4:0]    wr_sel;
  logic [31:0]   wr_data;
  logic          wr_hold;
  logic [4:0]    rd_sel1;
  logic [4:0]    rd_sel2;
  logic [31:0]   rd_dat1;
  logic [31:0]   rd_dat2;
  logic          rf_WEN;
  logic [4:0]    rf_wsel;
  logic [31:0]   rf_wdat;
  logic [4:0]    rf_rsel1;
  logic [4:0]    rf_rsel2;
  logic [31:0]   rf_rdat1;
  logic [31:0]   rf_rdat2;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  int total = 0;
  int bad   = 0;

  // Reference: pending writes as a plain queue of {sel, data}, oldest first.
  logic [36:0] q[$];

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel), .wr_data(wr_data),
    .wr_hold(wr_hold),
    .rd_sel1(rd_sel1), .rd_sel2(rd_sel2), .rd_dat1(rd_dat1), .rd_dat2(rd_dat2),
    .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
    .rf_rsel1(rf_rsel1), .rf_rsel2(rf_rsel2), .rf_rdat1(rf_rdat1), .rf_rdat2(rf_rdat2),
    .count(count), .empty(empty), .full(full)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] s, input logic [31:0] rf);
    logic [31:0] r;
    if (s == 5'd0) return 32'd0;
    r = rf;
    foreach (q[i]) if (q[i][36:32] == s) r = q[i][31:0];
    return r;
  endfunction

  task automatic check_model();
    logic do_pop;
    do_pop = (q.size() > 0) && !wr_hold;
    chk("count",    32'(count),    32'(q.size()));
    chk("empty",    32'(empty),    32'(q.size() == 0));
    chk("full",     32'(full),     32'(q.size() == DEPTH));
    chk("wr_ready", 32'(wr_ready), 32'(q.size() < DEPTH));
    chk("rf_WEN",   32'(rf_WEN),   32'(do_pop));
    chk("rf_wsel",  32'(rf_wsel),  do_pop ? 32'(q[0][36:32]) : 32'd0);
    chk("rf_wdat",  rf_wdat,       do_pop ? q[0][31:0] : 32'd0);
    chk("rf_rsel1", 32'(rf_rsel1), 32'(rd_sel1));
    chk("rf_rsel2", 32'(rf_rsel2), 32'(rd_sel2));
    chk("rd_dat1",  rd_dat1,       model_read(rd_sel1, rf_rdat1));
    chk("rd_dat2",  rd_dat2,       model_read(rd_sel2, rf_rdat2));
  endtask

  // One cycle: check before the edge, advance the model at the edge, return just after it.
  task automatic tick();
    logic do_pop;
    logic do_acc;
    @(negedge CLK);
    check_model();
    do_pop = (q.size() > 0) && !wr_hold;
    do_acc = wr_valid && (q.size() < DEPTH);
    @(posedge CLK);
    if (nRST) begin
      if (do_pop) void'(q.pop_front());
      if (do_acc && wr_sel != 5'd0) q.push_back({wr_sel, wr_data});
    end
    #1;
  endtask

  task automatic push(input logic [4:0] s, input logic [31:0] d);
    wr_valid = 1'b1; wr_sel = s; wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; wr_valid = 1'b0; wr_sel = 5'd0; wr_data = 32'd0; wr_hold = 1'b0;
    rd_sel1 = 5'd0; rd_sel2 = 5'd0; rf_rdat1 = 32'hA5A5_0001; rf_rdat2 = 32'h5A5A_0002;

    // Reset state.
    #2;
    chk("rst_ready", 32'(wr_ready), 32'd1);
    chk("rst_empty", 32'(empty),    32'd1);
    chk("rst_full",  32'(full),     32'd0);
    chk("rst_wen",   32'(rf_WEN),   32'd0);
    chk("rst_count", 32'(count),    32'd0);
    tick(); tick();
    nRST = 1'b1;
    tick();

    // Single write, bypassed while it is being retired.
    rd_sel1 = 5'd5;
    push(5'd5, 32'hDEADBEEF);
    #1;
    chk("sw_count1", 32'(count),   32'd1);
    chk("sw_wen",    32'(rf_WEN),  32'd1);
    chk("sw_wsel",   32'(rf_wsel), 32'd5);
    chk("sw_wdat",   rf_wdat,      32'hDEADBEEF);
    chk("sw_byp",    rd_dat1,      32'hDEADBEEF);
    tick();
    chk("sw_count0", 32'(count),   32'd0);

    // Fill under hold, then drain in order.
    wr_hold = 1'b1;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'h100 + 32'(i));
    chk("fill_full",  32'(full),     32'd1);
    chk("fill_ready", 32'(wr_ready), 32'd0);
    chk("fill_count", 32'(count),    32'd4);
    chk("fill_wen",   32'(rf_WEN),   32'd0);
    push(5'd9, 32'h999);
    wr_hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("drain_sel", 32'(rf_wsel), 32'(i));
      tick();
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Youngest matching entry wins; both retire in order.
    wr_hold = 1'b1; rd_sel1 = 5'd7;
    push(5'd7, 32'h11);
    push(5'd7, 32'h22);
    #1;
    chk("yw_byp", rd_dat1, 32'h22);
    wr_hold = 1'b0;
    #1;
    chk("yw_first", rf_wdat, 32'h11);
    tick();
    chk("yw_second", rf_wdat, 32'h22);
    tick();

    // Register zero is consumed without effect and reads as zero.
    rd_sel2 = 5'd0; rf_rdat2 = 32'h1234;
    push(5'd0, 32'hFFFFFFFF);
    chk("r0_count", 32'(count),  32'd0);
    chk("r0_wen",   32'(rf_WEN), 32'd0);
    chk("r0_rd",    rd_dat2,     32'd0);

    // Simultaneous push/pop at DEPTH-1 across the pointer wrap.
    wr_hold = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) push(5'(10 + i), 32'h200 + 32'(i));
    wr_hold = 1'b0;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      push(5'(20 + i), 32'h300 + 32'(i));
      chk("pp_count", 32'(count), 32'(DEPTH - 1));
    end
    for (int i = 0; i < DEPTH; i++) tick();

    // Reset asserted between edges while draining.
    wr_hold = 1'b1;
    for (int i = 0; i < 3; i++) push(5'(i + 1), 32'h400 + 32'(i));
    wr_hold = 1'b0;
    tick();
    #2;
    nRST = 1'b0;
    #1;
    chk("rm_count", 32'(count),    32'd0);
    chk("rm_wen",   32'(rf_WEN),   32'd0);
    chk("rm_ready", 32'(wr_ready), 32'd1);
    q.delete();
    tick();
    #3;
    nRST = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // Randomized traffic with colliding register indices.
    for (int n = 0; n < 400; n++) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_sel   = 5'($urandom_range(0, 7));
      wr_data  = $urandom;
      wr_hold  = ($urandom_range(0, 9) < 4);
      rd_sel1  = 5'($urandom_range(0, 7));
      rd_sel2  = 5'($urandom_range(0, 7));
      rf_rdat1 = $urandom;
      rf_rdat2 = $urandom;
      tick();
    end
    wr_valid = 1'b0; wr_hold = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    chk("end_empty", 32'(empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
